// File: rtl/uxn_screen_pkg.sv
// Shared constants, FSM state encoding and draw-word packing helpers
// for the Varvara screen device encoder.
package uxn_screen_pkg;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 288;

  localparam logic [3:0] PORT_AUTO   = 4'h6;
  localparam logic [3:0] PORT_X_HI   = 4'h8;
  localparam logic [3:0] PORT_X_LO   = 4'h9;
  localparam logic [3:0] PORT_Y_HI   = 4'hA;
  localparam logic [3:0] PORT_Y_LO   = 4'hB;
  localparam logic [3:0] PORT_A_HI   = 4'hC;
  localparam logic [3:0] PORT_A_LO   = 4'hD;
  localparam logic [3:0] PORT_PIXEL  = 4'hE;
  localparam logic [3:0] PORT_SPRITE = 4'hF;

  localparam int W0_LAYER = 23;
  localparam int W0_COLOR = 21;
  localparam int W0_FILL  = 20;
  localparam int W0_B19   = 19;
  localparam int W0_B18   = 18;
  localparam int W0_X     = 9;
  localparam int W0_Y     = 0;
  localparam int W1_FY    = 19;
  localparam int W1_FX    = 18;
  localparam int W1_COLH  = 16;
  localparam int W1_ADDR  = 0;

  // The all-zero word is the queue's empty marker; this is the equivalent 1x1 fill.
  localparam logic [23:0] EMPTY_SUBST = 24'h1C0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_W0   = 2'd1;
  localparam logic [1:0] ST_W1   = 2'd2;

  function automatic logic [23:0] pack_w0(input logic layer, input logic [1:0] color,
                                          input logic fill, input logic b19, input logic b18,
                                          input logic [8:0] x, input logic [8:0] y);
    logic [23:0] w;
    w = '0;
    w[W0_LAYER]            = layer;
    w[W0_COLOR +: 2]       = color;
    w[W0_FILL]             = fill;
    w[W0_B19]              = b19;
    w[W0_B18]              = b18;
    w[W0_X +: 9]           = x;
    w[W0_Y +: 9]           = y;
    return w;
  endfunction

  function automatic logic [23:0] pack_w1(input logic fy, input logic fx,
                                          input logic [1:0] color_hi, input logic [15:0] addr);
    logic [23:0] w;
    w = '0;
    w[W1_FY]         = fy;
    w[W1_FX]         = fx;
    w[W1_COLH +: 2]  = color_hi;
    w[W1_ADDR +: 16] = addr;
    return w;
  endfunction

endpackage

// File: rtl/uxn_screen_regs.sv
// Screen device port register file (x, y, addr, auto) with registered read mux.
module uxn_screen_regs
  import uxn_screen_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [3:0]  i_port,
  input  logic [7:0]  i_wdata,
  input  logic [3:0]  i_rport,
  input  logic        i_upd,
  input  logic [15:0] i_x_nxt,
  input  logic [15:0] i_y_nxt,
  input  logic [15:0] i_addr_nxt,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic [15:0] o_addr,
  output logic [7:0]  o_auto,
  output logic [7:0]  o_rdata
);

  localparam logic [15:0] LP_W = 16'(SCREEN_W);
  localparam logic [15:0] LP_H = 16'(SCREEN_H);

  logic [15:0] r_x, r_y, r_addr;
  logic [7:0]  r_auto, r_rdata;
  logic [7:0]  w_rmux;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
      r_auto <= '0;
    end else if (i_upd) begin
      r_x    <= i_x_nxt;
      r_y    <= i_y_nxt;
      r_addr <= i_addr_nxt;
    end else if (i_we) begin
      case (i_port)
        PORT_AUTO: r_auto       <= i_wdata;
        PORT_X_HI: r_x[15:8]    <= i_wdata;
        PORT_X_LO: r_x[7:0]     <= i_wdata;
        PORT_Y_HI: r_y[15:8]    <= i_wdata;
        PORT_Y_LO: r_y[7:0]     <= i_wdata;
        PORT_A_HI: r_addr[15:8] <= i_wdata;
        PORT_A_LO: r_addr[7:0]  <= i_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rmux = 8'h00;
    case (i_rport)
      4'h2:      w_rmux = LP_W[15:8];
      4'h3:      w_rmux = LP_W[7:0];
      4'h4:      w_rmux = LP_H[15:8];
      4'h5:      w_rmux = LP_H[7:0];
      PORT_AUTO: w_rmux = r_auto;
      PORT_X_HI: w_rmux = r_x[15:8];
      PORT_X_LO: w_rmux = r_x[7:0];
      PORT_Y_HI: w_rmux = r_y[15:8];
      PORT_Y_LO: w_rmux = r_y[7:0];
      PORT_A_HI: w_rmux = r_addr[15:8];
      PORT_A_LO: w_rmux = r_addr[7:0];
      default:   w_rmux = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rdata <= '0;
    else       r_rdata <= w_rmux;
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_addr  = r_addr;
  assign o_auto  = r_auto;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/uxn_screen_encoder.sv
// Converts screen device pixel/sprite writes into packed draw-queue words,
// including the sprite auto-repeat sequencer.
module uxn_screen_encoder
  import uxn_screen_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dev_we,
  input  logic [3:0]  i_dev_port,
  input  logic [7:0]  i_dev_wdata,
  input  logic [3:0]  i_dev_rport,
  output logic [7:0]  o_dev_rdata,
  output logic [23:0] o_queue_data,
  output logic        o_queue_we,
  output logic        o_busy
);

  localparam logic [15:0] LP_W = 16'(SCREEN_W);
  localparam logic [15:0] LP_H = 16'(SCREEN_H);

  logic [1:0]  r_state;
  logic [7:0]  r_spr;
  logic [15:0] r_px, r_py, r_sa;
  logic [3:0]  r_i;
  logic [23:0] r_qdata;
  logic        r_qwe;

  logic [15:0] w_x, w_y, w_addr;
  logic [7:0]  w_auto;
  logic        w_we, w_pix, w_spr, w_last, w_upd;
  logic [15:0] w_dx, w_dy, w_sa_n, w_px_n, w_py_n;
  logic [15:0] w_x_nxt, w_y_nxt, w_addr_nxt;
  logic [15:0] w_xc, w_yc;
  logic        w_xoob, w_yoob, w_pix_ok;
  logic [23:0] w_pix_word;

  assign o_busy = (r_state != ST_IDLE);
  assign w_we   = i_dev_we && !o_busy;
  assign w_pix  = w_we && (i_dev_port == PORT_PIXEL);
  assign w_spr  = w_we && (i_dev_port == PORT_SPRITE);

  uxn_screen_regs #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_regs (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (w_we),
    .i_port     (i_dev_port),
    .i_wdata    (i_dev_wdata),
    .i_rport    (i_dev_rport),
    .i_upd      (w_upd),
    .i_x_nxt    (w_x_nxt),
    .i_y_nxt    (w_y_nxt),
    .i_addr_nxt (w_addr_nxt),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_addr     (w_addr),
    .o_auto     (w_auto),
    .o_rdata    (o_dev_rdata)
  );

  // Pixel path: plain pixel or clamped fill, resolved in the write cycle.
  always_comb begin
    w_xoob = (w_x >= LP_W);
    w_yoob = (w_y >= LP_H);
    w_xc   = w_xoob ? (LP_W - 16'd1) : w_x;
    w_yc   = w_yoob ? (LP_H - 16'd1) : w_y;
    if (i_dev_wdata[7]) begin
      w_pix_ok   = !((!i_dev_wdata[4] && w_xoob) || (!i_dev_wdata[5] && w_yoob));
      w_pix_word = pack_w0(i_dev_wdata[6], i_dev_wdata[1:0], 1'b1, i_dev_wdata[5],
                           i_dev_wdata[4], w_xc[8:0], w_yc[8:0]);
    end else begin
      w_pix_ok   = !w_xoob && !w_yoob;
      w_pix_word = pack_w0(i_dev_wdata[6], i_dev_wdata[1:0], 1'b0, 1'b0, 1'b0,
                           w_x[8:0], w_y[8:0]);
      if (w_pix_word == 24'h0) w_pix_word = EMPTY_SUBST;
    end
  end

  // Sprite stepping: ax walks py, ay walks px (Varvara convention).
  assign w_dx   = w_auto[0] ? (r_spr[4] ? 16'hFFF8 : 16'd8) : 16'd0;
  assign w_dy   = w_auto[1] ? (r_spr[5] ? 16'hFFF8 : 16'd8) : 16'd0;
  assign w_sa_n = w_auto[2] ? (r_sa + (r_spr[7] ? 16'd16 : 16'd8)) : r_sa;
  assign w_px_n = r_px + w_dy;
  assign w_py_n = r_py + w_dx;
  assign w_last = (r_state == ST_W1) && (r_i >= w_auto[7:4]);

  always_comb begin
    w_upd      = 1'b0;
    w_x_nxt    = w_x;
    w_y_nxt    = w_y;
    w_addr_nxt = w_addr;
    if (w_pix) begin
      w_upd   = 1'b1;
      w_x_nxt = w_x + {15'd0, w_auto[0]};
      w_y_nxt = w_y + {15'd0, w_auto[1]};
    end else if (w_last) begin
      w_upd      = 1'b1;
      w_x_nxt    = w_x + w_dx;
      w_y_nxt    = w_y + w_dy;
      w_addr_nxt = w_sa_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_spr   <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_sa    <= '0;
      r_i     <= '0;
      r_qdata <= '0;
      r_qwe   <= 1'b0;
    end else begin
      r_qwe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pix) begin
            r_qwe <= w_pix_ok;
            if (w_pix_ok) r_qdata <= w_pix_word;
          end else if (w_spr) begin
            r_spr   <= i_dev_wdata;
            r_px    <= w_x;
            r_py    <= w_y;
            r_sa    <= w_addr;
            r_i     <= '0;
            r_state <= ST_W0;
            r_qwe   <= (w_x < 16'd512) && (w_y < 16'd512);
            r_qdata <= pack_w0(i_dev_wdata[6], i_dev_wdata[1:0], 1'b0, 1'b1,
                               i_dev_wdata[7], w_x[8:0], w_y[8:0]);
          end
        end
        ST_W0: begin
          r_state <= ST_W1;
          r_qwe   <= (r_px < 16'd512) && (r_py < 16'd512);
          r_qdata <= pack_w1(r_spr[5], r_spr[4], r_spr[3:2], r_sa);
        end
        ST_W1: begin
          if (w_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_W0;
            r_i     <= r_i + 4'd1;
            r_px    <= w_px_n;
            r_py    <= w_py_n;
            r_sa    <= w_sa_n;
            r_qwe   <= (w_px_n < 16'd512) && (w_py_n < 16'd512);
            r_qdata <= pack_w0(r_spr[6], r_spr[1:0], 1'b0, 1'b1, r_spr[7],
                               w_px_n[8:0], w_py_n[8:0]);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_queue_data = r_qdata;
  assign o_queue_we   = r_qwe;

endmodule

// File: tb/tb_uxn_screen_encoder.sv
// Directed self-checking bench for uxn_screen_encoder.
module tb_uxn_screen_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_dev_we = 1'b0;
  logic [3:0]  i_dev_port = 4'h0;
  logic [7:0]  i_dev_wdata = 8'h00;
  logic [3:0]  i_dev_rport = 4'h0;
  logic [7:0]  o_dev_rdata;
  logic [23:0] o_queue_data;
  logic        o_queue_we;
  logic        o_busy;

  int n_chk = 0;
  int n_err = 0;
  int busy_cnt = 0;
  logic [23:0] q_log[$];
  logic [7:0]  rv;

  uxn_screen_encoder dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_dev_we     (i_dev_we),
    .i_dev_port   (i_dev_port),
    .i_dev_wdata  (i_dev_wdata),
    .i_dev_rport  (i_dev_rport),
    .o_dev_rdata  (o_dev_rdata),
    .o_queue_data (o_queue_data),
    .o_queue_we   (o_queue_we),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_queue_we) q_log.push_back(o_queue_data);
    if (o_busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int k);
    if (k < q_log.size()) return {8'h00, q_log[k]};
    return 32'hDEADBEEF;
  endfunction

  task automatic wr(input logic [3:0] p, input logic [7:0] d);
    @(negedge i_clk);
    i_dev_we = 1'b1; i_dev_port = p; i_dev_wdata = d;
    @(negedge i_clk);
    i_dev_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] p, output logic [7:0] d);
    @(negedge i_clk);
    i_dev_rport = p;
    @(negedge i_clk);
    d = o_dev_rdata;
  endtask

  task automatic clr_log();
    @(posedge i_clk);
    #1;
    q_log.delete();
    busy_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    // 1. reset state
    repeat (3) @(negedge i_clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_qwe", {31'd0, o_queue_we}, 32'd0);
    chk("rst_qdata", {8'd0, o_queue_data}, 32'd0);
    i_rst = 1'b0;
    rd(4'h2, rv); chk("rd_w_hi", {24'd0, rv}, 32'h01);
    rd(4'h3, rv); chk("rd_w_lo", {24'd0, rv}, 32'h40);
    rd(4'h4, rv); chk("rd_h_hi", {24'd0, rv}, 32'h01);
    rd(4'h5, rv); chk("rd_h_lo", {24'd0, rv}, 32'h20);
    rd(4'h8, rv); chk("rd_x_rst", {24'd0, rv}, 32'h00);

    // 2. auto-x pixel
    wr(4'h9, 8'h05); wr(4'hB, 8'h03); wr(4'h6, 8'h01);
    clr_log();
    wr(4'hE, 8'h41);
    chk("pix_we_t1", {31'd0, o_queue_we}, 32'd1);
    chk("pix_data", {8'd0, o_queue_data}, 32'hA00A03);
    idle(3);
    chk("pix_cnt", q_log.size(), 32'd1);
    rd(4'h9, rv); chk("pix_ax", {24'd0, rv}, 32'h06);
    wr(4'h3, 8'h99);
    rd(4'h3, rv); chk("ro_port3", {24'd0, rv}, 32'h40);

    // 3. empty substitution and off-screen drop
    wr(4'h6, 8'h00); wr(4'h9, 8'h00); wr(4'hB, 8'h00);
    clr_log();
    wr(4'hE, 8'h00);
    idle(3);
    chk("empty_cnt", q_log.size(), 32'd1);
    chk("empty_sub", log_at(0), 32'h1C0000);
    wr(4'h8, 8'h01); wr(4'h9, 8'h40);
    clr_log();
    wr(4'hE, 8'h41);
    idle(3);
    chk("pix_drop", q_log.size(), 32'd0);

    // 4. fills
    wr(4'h8, 8'h00); wr(4'h9, 8'h0A); wr(4'hB, 8'h14);
    clr_log();
    wr(4'hE, 8'h93);
    idle(3);
    chk("fill_cnt", q_log.size(), 32'd1);
    chk("fill_data", log_at(0), 32'h741414);
    wr(4'h8, 8'h01); wr(4'h9, 8'h90);
    clr_log();
    wr(4'hE, 8'h93);
    idle(3);
    chk("fill_clamp", log_at(0), 32'h767E14);
    clr_log();
    wr(4'hE, 8'h83);
    idle(3);
    chk("fill_drop", q_log.size(), 32'd0);

    // 5. auto-repeat sprite
    wr(4'h6, 8'h25);
    wr(4'h8, 8'h00); wr(4'h9, 8'h10);
    wr(4'hA, 8'h00); wr(4'hB, 8'h08);
    wr(4'hC, 8'h10); wr(4'hD, 8'h00);
    clr_log();
    wr(4'hF, 8'h81);
    wr(4'h8, 8'h55);
    rd(4'h9, rv); chk("spr_rd_busy", {24'd0, rv}, 32'h10);
    idle(10);
    chk("spr_cnt", q_log.size(), 32'd6);
    chk("spr_w0a", log_at(0), 32'h2C2008);
    chk("spr_w1a", log_at(1), 32'h001000);
    chk("spr_w0b", log_at(2), 32'h2C2010);
    chk("spr_w1b", log_at(3), 32'h001010);
    chk("spr_w0c", log_at(4), 32'h2C2018);
    chk("spr_w1c", log_at(5), 32'h001020);
    chk("spr_busy", busy_cnt, 32'd6);
    rd(4'h8, rv); chk("spr_x_hi", {24'd0, rv}, 32'h00);
    rd(4'h9, rv); chk("spr_x_lo", {24'd0, rv}, 32'h18);
    rd(4'hB, rv); chk("spr_y_lo", {24'd0, rv}, 32'h08);
    rd(4'hC, rv); chk("spr_a_hi", {24'd0, rv}, 32'h10);
    rd(4'hD, rv); chk("spr_a_lo", {24'd0, rv}, 32'h30);

    // 6. off-range sprite
    wr(4'h6, 8'h00); wr(4'h8, 8'hFF); wr(4'h9, 8'hF8);
    clr_log();
    wr(4'hF, 8'h01);
    idle(6);
    chk("off_cnt", q_log.size(), 32'd0);
    chk("off_busy", busy_cnt, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
